// File: rtl/led_panel_pkg.sv
// Shared types and field layout for the BCM LED panel driver.
package led_panel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_LATCH,
    ST_ON,
    ST_OFF
  } state_t;

  // Pixel word is {R,G,B}, each colour_bits wide, R in the MSBs.
  function automatic int pix_w(input int colour_bits);
    return 3 * colour_bits;
  endfunction

  function automatic int r_off(input int colour_bits);
    return 2 * colour_bits;
  endfunction

  function automatic int g_off(input int colour_bits);
    return colour_bits;
  endfunction

  function automatic int b_off(input int colour_bits);
    return 0 * colour_bits;
  endfunction

endpackage

// File: rtl/led_panel_fb.sv
// Flop-based frame buffer: one write port with clear, two combinational
// plane-bit read ports (upper-half row and matching lower-half row).
module led_panel_fb
  import led_panel_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int SCAN_ROWS  = 4,
  parameter int COLOR_BITS = 2,
  localparam int XW    = $clog2(COLS),
  localparam int RW    = $clog2(SCAN_ROWS),
  localparam int YW    = RW + 1,
  localparam int PW    = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1,
  localparam int PIX_W = pix_w(COLOR_BITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [XW-1:0]    wr_x_i,
  input  logic [YW-1:0]    wr_y_i,
  input  logic [PIX_W-1:0] wr_rgb_i,
  input  logic [XW-1:0]    rd_x_i,
  input  logic [RW-1:0]    rd_row_i,
  input  logic [PW-1:0]    rd_plane_i,
  output logic [2:0]       rgb0_o,
  output logic [2:0]       rgb1_o
);

  localparam int R_OFF = r_off(COLOR_BITS);
  localparam int G_OFF = g_off(COLOR_BITS);
  localparam int B_OFF = b_off(COLOR_BITS);

  logic [PIX_W-1:0] mem_q [2*SCAN_ROWS][COLS];
  logic [PIX_W-1:0] pix0, pix1, sh0, sh1;

  always_ff @(posedge clk) begin
    if (!reset_n || clr_i) begin
      for (int unsigned y = 0; y < 2 * SCAN_ROWS; y++) begin
        for (int unsigned x = 0; x < COLS; x++) begin
          mem_q[y][x] <= '0;
        end
      end
    end else if (wr_en_i && (int'(wr_x_i) < COLS)) begin
      mem_q[wr_y_i][wr_x_i] <= wr_rgb_i;
    end
  end

  // Lower-half row is row+SCAN_ROWS, i.e. the row address with the top y bit set.
  always_comb begin
    pix0   = mem_q[{1'b0, rd_row_i}][rd_x_i];
    pix1   = mem_q[{1'b1, rd_row_i}][rd_x_i];
    sh0    = pix0 >> rd_plane_i;
    sh1    = pix1 >> rd_plane_i;
    rgb0_o = {sh0[R_OFF], sh0[G_OFF], sh0[B_OFF]};
    rgb1_o = {sh1[R_OFF], sh1[G_OFF], sh1[B_OFF]};
  end

endmodule

// File: rtl/led_panel_bcm.sv
// HUB75-style 1/SCAN_ROWS-scan RGB panel driver using binary-coded modulation:
// shift a bit plane, latch it, light it for BLANK_BASE<<plane cycles, repeat.
module led_panel_bcm
  import led_panel_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int SCAN_ROWS  = 4,
  parameter int COLOR_BITS = 2,
  parameter int BLANK_BASE = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [$clog2(COLS)-1:0]        wr_x,
  input  logic [$clog2(2*SCAN_ROWS)-1:0] wr_y,
  input  logic [3*COLOR_BITS-1:0]        wr_rgb,
  output logic [1:0]                     red_out,
  output logic [1:0]                     green_out,
  output logic [1:0]                     blue_out,
  output logic                           sclk_out,
  output logic                           latch_out,
  output logic                           blank_out,
  output logic [$clog2(SCAN_ROWS)-1:0]   row_out,
  output logic                           frame_done
);

  localparam int XW     = $clog2(COLS);
  localparam int RW     = $clog2(SCAN_ROWS);
  localparam int PW     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int ON_MAX = BLANK_BASE << (COLOR_BITS - 1);
  localparam int ON_W   = (ON_MAX > 1) ? $clog2(ON_MAX) : 1;

  localparam logic [XW-1:0] COL_MAX   = XW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(SCAN_ROWS - 1);
  localparam logic [PW-1:0] PLANE_MAX = PW'(COLOR_BITS - 1);

  state_t          state_q;
  logic [XW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [PW-1:0]   plane_q;
  logic [ON_W-1:0] on_q;
  logic [1:0]      red_q, green_q, blue_q;
  logic            gate_q, latch_q, blank_q, done_q;
  logic [2:0]      rgb0, rgb1;

  led_panel_fb #(
    .COLS       (COLS),
    .SCAN_ROWS  (SCAN_ROWS),
    .COLOR_BITS (COLOR_BITS)
  ) u_fb (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .wr_en_i    (wr_en),
    .wr_x_i     (wr_x),
    .wr_y_i     (wr_y),
    .wr_rgb_i   (wr_rgb),
    .rd_x_i     (col_q),
    .rd_row_i   (row_q),
    .rd_plane_i (plane_q),
    .rgb0_o     (rgb0),
    .rgb1_o     (rgb1)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      plane_q <= PLANE_MAX;
      on_q    <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      gate_q  <= 1'b0;
      latch_q <= 1'b0;
      blank_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          blank_q <= 1'b1;
          gate_q  <= 1'b0;
          if (enable) begin
            state_q <= ST_DATA;
            col_q   <= COL_MAX;
          end
        end
        ST_DATA: begin
          red_q   <= {rgb1[2], rgb0[2]};
          green_q <= {rgb1[1], rgb0[1]};
          blue_q  <= {rgb1[0], rgb0[0]};
          gate_q  <= 1'b1;
          if (col_q == '0) state_q <= ST_LATCH;
          else             col_q   <= col_q - 1'b1;
        end
        ST_LATCH: begin
          gate_q  <= 1'b0;
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
          latch_q <= 1'b1;
          on_q    <= ON_W'((BLANK_BASE << plane_q) - 1);
          state_q <= ST_ON;
        end
        ST_ON: begin
          // Outputs lag state by one cycle, so blank drops the cycle after latch.
          blank_q <= 1'b0;
          if (on_q == '0) state_q <= ST_OFF;
          else            on_q    <= on_q - 1'b1;
        end
        ST_OFF: begin
          blank_q <= 1'b1;
          if (plane_q == '0) begin
            plane_q <= PLANE_MAX;
            if (row_q == ROW_MAX) begin
              row_q  <= '0;
              done_q <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            plane_q <= plane_q - 1'b1;
          end
          if (enable) begin
            state_q <= ST_DATA;
            col_q   <= COL_MAX;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign red_out    = red_q;
  assign green_out  = green_q;
  assign blue_out   = blue_q;
  assign sclk_out   = gate_q ? ~clk : 1'b1;
  assign latch_out  = latch_q;
  assign blank_out  = blank_q;
  assign row_out    = row_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_panel_bcm.sv
// Directed bench for led_panel_bcm: per-plane capture of panel pin activity
// compared against hand-computed counts and pixel positions.
module tb_led_panel_bcm;

  logic       clk = 1'b0;
  logic       reset_n, enable, clr, wr_en;
  logic [4:0] wr_x;
  logic [2:0] wr_y;
  logic [5:0] wr_rgb;
  logic [1:0] red_out, green_out, blue_out, row_out;
  logic       sclk_out, latch_out, blank_out, frame_done;

  logic       en2, clr2, wr_en2;
  logic [4:0] wr_x2;
  logic [1:0] wr_y2;
  logic [2:0] wr_rgb2;
  logic [1:0] red2, green2, blue2;
  logic [0:0] row2;
  logic       sclk2, latch2, blank2, done2;

  int n_vec = 0;
  int n_err = 0;
  int n_inv = 0;
  logic [1:0] prev_row = '0;

  always #5 clk = ~clk;

  led_panel_bcm dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr), .wr_en(wr_en),
    .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .sclk_out(sclk_out), .latch_out(latch_out), .blank_out(blank_out),
    .row_out(row_out), .frame_done(frame_done)
  );

  // Non-power-of-two width so an out-of-range column is representable.
  led_panel_bcm #(.COLS(30), .SCAN_ROWS(2), .COLOR_BITS(1), .BLANK_BASE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(en2), .clr(clr2), .wr_en(wr_en2),
    .wr_x(wr_x2), .wr_y(wr_y2), .wr_rgb(wr_rgb2),
    .red_out(red2), .green_out(green2), .blue_out(blue2),
    .sclk_out(sclk2), .latch_out(latch2), .blank_out(blank2),
    .row_out(row2), .frame_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [4:0] x, input logic [2:0] y, input logic [5:0] rgb);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  // One plane: from just after the previous plane's blank rise to this plane's blank rise.
  task automatic capture(input int drop_at, output int nsclk, output int nlatch, output int nlow,
                         output int nhit, output int hit_idx, output logic [5:0] hit_val,
                         output int row, output int ndone);
    bit low_seen = 0;
    bit fin = 0;
    nsclk = 0; nlatch = 0; nlow = 0; nhit = 0; hit_idx = -1; hit_val = '0; row = -1; ndone = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      if (k == drop_at) enable = 1'b0;
      tick();
      if (sclk_out == 1'b0) begin
        if (nsclk == 0) row = int'(row_out);
        if ({red_out, green_out, blue_out} != 6'b0) begin
          nhit++; hit_idx = nsclk; hit_val = {red_out, green_out, blue_out};
        end
        nsclk++;
      end
      if (latch_out) nlatch++;
      if (frame_done) ndone++;
      if (latch_out && !blank_out) n_inv++;
      if (!blank_out && row_out != prev_row) n_inv++;
      prev_row = row_out;
      if (!blank_out) begin
        nlow++; low_seen = 1;
      end else if (low_seen) begin
        fin = 1;
      end
    end
    check("capture_done", 32'(fin), 32'd1);
  endtask

  int ns, nl, nlo, nh, hi, rw, nd, anomalies, tot_hits, tot_done;
  logic [5:0] hv;
  int exp_row[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    reset_n = 1'b0; enable = 1'b0; clr = 1'b0; wr_en = 1'b0;
    wr_x = '0; wr_y = '0; wr_rgb = '0;
    en2 = 1'b0; clr2 = 1'b0; wr_en2 = 1'b0; wr_x2 = '0; wr_y2 = '0; wr_rgb2 = '0;

    // T1: reset and idle
    repeat (3) tick();
    check("rst_blank", 32'(blank_out), 32'd1);
    check("rst_latch", 32'(latch_out), 32'd0);
    check("rst_sclk", 32'(sclk_out), 32'd1);
    check("rst_colour", 32'({red_out, green_out, blue_out}), 32'd0);
    check("rst_row", 32'(row_out), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    anomalies = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!blank_out || !sclk_out || latch_out) anomalies++;
    end
    check("idle_hold", 32'(anomalies), 32'd0);

    // T2/T3 pixels, then one full frame
    write_px(5'd5, 3'd1, 6'b11_00_10);
    write_px(5'd0, 3'd6, 6'b01_00_00);
    enable = 1'b1;
    tot_done = 0;
    for (int p = 0; p < 8; p++) begin
      capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
      tot_done += nd;
      check($sformatf("p%0d_row", p), 32'(rw), 32'(exp_row[p]));
      check($sformatf("p%0d_sclk", p), 32'(ns), 32'd32);
      check($sformatf("p%0d_latch", p), 32'(nl), 32'd1);
      check($sformatf("p%0d_low", p), 32'(nlo), (p % 2 == 0) ? 32'd32 : 32'd16);
      check($sformatf("p%0d_done", p), 32'(nd), (p == 7) ? 32'd1 : 32'd0);
      case (p)
        2: begin
          check("t2_p1_hits", 32'(nh), 32'd1);
          check("t2_p1_idx", 32'(hi), 32'd26);
          check("t2_p1_val", 32'(hv), 32'(6'b01_00_01));
        end
        3: begin
          check("t2_p0_hits", 32'(nh), 32'd1);
          check("t2_p0_idx", 32'(hi), 32'd26);
          check("t2_p0_val", 32'(hv), 32'(6'b01_00_00));
        end
        5: begin
          check("t3_hits", 32'(nh), 32'd1);
          check("t3_idx", 32'(hi), 32'd31);
          check("t3_val", 32'(hv), 32'(6'b10_00_00));
        end
        default: check($sformatf("p%0d_hits", p), 32'(nh), 32'd0);
      endcase
    end
    check("frame_done_count", 32'(tot_done), 32'd1);

    // T4: wrap back to row 0 plane 1
    capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
    check("wrap_row", 32'(rw), 32'd0);
    check("wrap_low", 32'(nlo), 32'd32);

    // T5: drop enable during DATA of row 0 plane 0
    capture(5, ns, nl, nlo, nh, hi, hv, rw, nd);
    check("drop_sclk", 32'(ns), 32'd32);
    check("drop_latch", 32'(nl), 32'd1);
    check("drop_low", 32'(nlo), 32'd16);
    anomalies = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!blank_out || !sclk_out || latch_out) anomalies++;
    end
    check("parked", 32'(anomalies), 32'd0);
    enable = 1'b1;
    capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
    check("resume_row", 32'(rw), 32'd1);
    check("resume_low", 32'(nlo), 32'd32);

    // T6: clr beats wr_en; then a full frame shows no data
    enable = 1'b0;
    capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
    clr = 1'b1;
    write_px(5'd3, 3'd0, 6'b11_11_11);
    clr = 1'b0;
    enable = 1'b1;
    tot_hits = 0;
    for (int p = 0; p < 8; p++) begin
      capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
      tot_hits += nh;
    end
    check("clr_hits", 32'(tot_hits), 32'd0);
    check("invariants", 32'(n_inv), 32'd0);

    // Reset during ON
    anomalies = 1;
    for (int i = 0; i < 300 && anomalies != 0; i++) begin
      tick();
      if (!blank_out) anomalies = 0;
    end
    check("reach_on", 32'(anomalies), 32'd0);
    reset_n = 1'b0;
    tick();
    check("rst_on_blank", 32'(blank_out), 32'd1);
    check("rst_on_latch", 32'(latch_out), 32'd0);
    check("rst_on_sclk", 32'(sclk_out), 32'd1);
    check("rst_on_row", 32'(row_out), 32'd0);
    reset_n = 1'b1;
    prev_row = '0;
    capture(-1, ns, nl, nlo, nh, hi, hv, rw, nd);
    check("post_rst_row", 32'(rw), 32'd0);
    check("post_rst_low", 32'(nlo), 32'd32);
    enable = 1'b0;

    // Out-of-range columns ignored (30-column instance)
    wr_en2 = 1'b1;
    wr_x2 = 5'd31; wr_y2 = 2'd0; wr_rgb2 = 3'b111; tick();
    wr_x2 = 5'd30; wr_y2 = 2'd3; wr_rgb2 = 3'b111; tick();
    wr_x2 = 5'd29; wr_y2 = 2'd1; wr_rgb2 = 3'b100; tick();
    wr_en2 = 1'b0;
    en2 = 1'b1;
    tot_hits = 0; tot_done = 0; hv = '0; hi = 0; ns = 0;
    for (int i = 0; i < 300 && tot_done == 0; i++) begin
      tick();
      if (sclk2 == 1'b0) begin
        if ({red2, green2, blue2} != 6'b0) begin
          tot_hits++; hv = {red2, green2, blue2}; hi = ns;
        end
        ns++;
      end
      if (done2) tot_done++;
    end
    check("oor_frame", 32'(tot_done), 32'd1);
    check("oor_hits", 32'(tot_hits), 32'd1);
    check("oor_val", 32'(hv), 32'(6'b01_00_00));
    check("oor_idx", 32'(hi), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule
